// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stall/flush,
// D/E forwarding selects, multicycle-multiplier tracking FSM and debug counters.
module hazard_controller #(
    parameter logic [2:0] WB_MEM       = 3'b001,
    parameter logic [2:0] WB_MULT      = 3'b100,
    parameter int         MULT_TIMEOUT = 64,
    parameter int         CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       branchD_i,
    input  logic [4:0]       RsD_i,
    input  logic [4:0]       RtD_i,
    input  logic             MultStartD_i,
    input  logic [2:0]       WBSrcD_i,
    input  logic [4:0]       RsE_i,
    input  logic [4:0]       RtE_i,
    input  logic [4:0]       WriteRegE_i,
    input  logic             RegWriteE_i,
    input  logic [2:0]       WBSrcE_i,
    input  logic             MultStartE_i,
    input  logic             MultDoneE_i,
    input  logic [4:0]       WriteRegM_i,
    input  logic             RegWriteM_i,
    input  logic [2:0]       WBSrcM_i,
    input  logic [4:0]       WriteRegW_i,
    input  logic             RegWriteW_i,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             flushE_o,
    output logic             forwardAD_o,
    output logic             forwardBD_o,
    output logic [1:0]       forwardAE_o,
    output logic [1:0]       forwardBE_o,
    output logic             mult_busy_o,
    output logic             mult_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TCNT_W = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MULT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lwstall_s, brstall_s, mstall_s, stall_s;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Stall sources: load-use, branch operand not yet forwardable, mult result pending.
    always_comb begin
        lwstall_s = (WBSrcE_i == WB_MEM) && (reg_hit(RtE_i, RsD_i) || reg_hit(RtE_i, RtD_i));
        brstall_s = (branchD_i != 2'b00) &&
                    ((RegWriteE_i && (reg_hit(WriteRegE_i, RsD_i) || reg_hit(WriteRegE_i, RtD_i))) ||
                     ((WBSrcM_i == WB_MEM) && (reg_hit(WriteRegM_i, RsD_i) || reg_hit(WriteRegM_i, RtD_i))));
        mstall_s  = (state_q == ST_BUSY) && (MultStartD_i || (WBSrcD_i == WB_MULT));
        stall_s   = !rst_i && (lwstall_s || brstall_s || mstall_s);
    end

    // Hazard outputs; reset forces a bubble into E and clears all forwards.
    always_comb begin
        stallF_o    = 1'b0;
        stallD_o    = 1'b0;
        flushE_o    = 1'b0;
        forwardAD_o = 1'b0;
        forwardBD_o = 1'b0;
        forwardAE_o = 2'b00;
        forwardBE_o = 2'b00;
        if (rst_i) begin
            flushE_o = 1'b1;
        end else begin
            stallF_o    = stall_s;
            stallD_o    = stall_s;
            flushE_o    = stall_s;
            forwardAD_o = RegWriteM_i && reg_hit(WriteRegM_i, RsD_i);
            forwardBD_o = RegWriteM_i && reg_hit(WriteRegM_i, RtD_i);
            if (RegWriteM_i && reg_hit(WriteRegM_i, RsE_i)) begin
                forwardAE_o = 2'b10;
            end else if (RegWriteW_i && reg_hit(WriteRegW_i, RsE_i)) begin
                forwardAE_o = 2'b01;
            end else begin
                forwardAE_o = 2'b00;
            end
            if (RegWriteM_i && reg_hit(WriteRegM_i, RtE_i)) begin
                forwardBE_o = 2'b10;
            end else if (RegWriteW_i && reg_hit(WriteRegW_i, RtE_i)) begin
                forwardBE_o = 2'b01;
            end else begin
                forwardBE_o = 2'b00;
            end
        end
    end

    // Multiplier tracking FSM next state and timeout counter.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (MultStartE_i && !MultDoneE_i) begin
                    state_d = ST_BUSY;
                    tcnt_d  = {TCNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (MultDoneE_i && MultStartE_i) begin
                    tcnt_d = {TCNT_W{1'b0}};
                end else if (MultDoneE_i) begin
                    state_d = ST_IDLE;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = {TCNT_W{1'b0}};
            end
        endcase
    end

    // Saturating count of stalled cycles.
    always_comb begin
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tcnt_q  <= {TCNT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs read as idle/clear for the whole reset cycle.
    always_comb begin
        if (rst_i) begin
            mult_busy_o = 1'b0;
            mult_err_o  = 1'b0;
            stall_cnt_o = {CNT_W{1'b0}};
        end else begin
            mult_busy_o = (state_q == ST_BUSY);
            mult_err_o  = (state_q == ST_ERR);
            stall_cnt_o = cnt_q;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: hazards, forwarding,
// multiplier FSM, timeout, reset and stall-counter saturation.
module tb_hazard_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  branchD_i;
    logic [4:0]  RsD_i, RtD_i, RsE_i, RtE_i, WriteRegE_i, WriteRegM_i, WriteRegW_i;
    logic        MultStartD_i, RegWriteE_i, MultStartE_i, MultDoneE_i, RegWriteM_i, RegWriteW_i;
    logic [2:0]  WBSrcD_i, WBSrcE_i, WBSrcM_i;
    logic        stallF_o, stallD_o, flushE_o, forwardAD_o, forwardBD_o;
    logic [1:0]  forwardAE_o, forwardBE_o;
    logic        mult_busy_o, mult_err_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    hazard_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .branchD_i(branchD_i), .RsD_i(RsD_i), .RtD_i(RtD_i),
        .MultStartD_i(MultStartD_i), .WBSrcD_i(WBSrcD_i), .RsE_i(RsE_i), .RtE_i(RtE_i),
        .WriteRegE_i(WriteRegE_i), .RegWriteE_i(RegWriteE_i), .WBSrcE_i(WBSrcE_i),
        .MultStartE_i(MultStartE_i), .MultDoneE_i(MultDoneE_i), .WriteRegM_i(WriteRegM_i),
        .RegWriteM_i(RegWriteM_i), .WBSrcM_i(WBSrcM_i), .WriteRegW_i(WriteRegW_i),
        .RegWriteW_i(RegWriteW_i), .stallF_o(stallF_o), .stallD_o(stallD_o), .flushE_o(flushE_o),
        .forwardAD_o(forwardAD_o), .forwardBD_o(forwardBD_o), .forwardAE_o(forwardAE_o),
        .forwardBE_o(forwardBE_o), .mult_busy_o(mult_busy_o), .mult_err_o(mult_err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        branchD_i = 2'b00; RsD_i = 5'd0; RtD_i = 5'd0; MultStartD_i = 1'b0; WBSrcD_i = 3'b000;
        RsE_i = 5'd0; RtE_i = 5'd0; WriteRegE_i = 5'd0; RegWriteE_i = 1'b0; WBSrcE_i = 3'b000;
        MultStartE_i = 1'b0; MultDoneE_i = 1'b0; WriteRegM_i = 5'd0; RegWriteM_i = 1'b0;
        WBSrcM_i = 3'b000; WriteRegW_i = 5'd0; RegWriteW_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        WBSrcE_i = 3'b001; RtE_i = 5'd2; RtD_i = 5'd2; RsD_i = 5'd5;
        RegWriteM_i = 1'b1; WriteRegM_i = 5'd5; RsE_i = 5'd5; MultStartE_i = 1'b1;
        tick(); tick(); #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL rst_stallD got=%0b exp=0", stallD_o); end
        n_cmp++; if (stallF_o !== 1'b0) begin n_err++; $display("FAIL rst_stallF got=%0b exp=0", stallF_o); end
        n_cmp++; if (flushE_o !== 1'b1) begin n_err++; $display("FAIL rst_flushE got=%0b exp=1", flushE_o); end
        n_cmp++; if ({forwardAD_o, forwardBD_o, forwardAE_o, forwardBE_o} !== 6'b0) begin n_err++; $display("FAIL rst_forwards got=%b exp=000000", {forwardAD_o, forwardBD_o, forwardAE_o, forwardBE_o}); end
        n_cmp++; if ({mult_busy_o, mult_err_o} !== 2'b00) begin n_err++; $display("FAIL rst_mult got=%b exp=00", {mult_busy_o, mult_err_o}); end
        n_cmp++; if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt_o); end
        clear_inputs();
        rst_i = 1'b0;
        tick();
        n_cmp++; if (mult_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_release_busy got=%0b exp=0", mult_busy_o); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        WBSrcE_i = 3'b001; RtE_i = 5'd2; RsD_i = 5'd2; #1;
        n_cmp++; if ({stallF_o, stallD_o, flushE_o} !== 3'b111) begin n_err++; $display("FAIL lw_rs_stall got=%b exp=111", {stallF_o, stallD_o, flushE_o}); end
        tick();
        clear_inputs(); #1;
        n_cmp++; if ({stallF_o, stallD_o, flushE_o} !== 3'b000) begin n_err++; $display("FAIL lw_release got=%b exp=000", {stallF_o, stallD_o, flushE_o}); end
        n_cmp++; if (stall_cnt_o !== 16'd1) begin n_err++; $display("FAIL lw_cnt got=%0d exp=1", stall_cnt_o); end
        WBSrcE_i = 3'b001; RtE_i = 5'd7; RtD_i = 5'd7; RsD_i = 5'd3; #1;
        n_cmp++; if (stallD_o !== 1'b1) begin n_err++; $display("FAIL lw_rt_stall got=%0b exp=1", stallD_o); end
        tick();
        n_cmp++; if (stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL lw_cnt2 got=%0d exp=2", stall_cnt_o); end
        RtE_i = 5'd0; RtD_i = 5'd0; RsD_i = 5'd0; #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL lw_r0 got=%0b exp=0", stallD_o); end
        WBSrcE_i = 3'b010; RtE_i = 5'd4; RsD_i = 5'd4; #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL lw_not_load got=%0b exp=0", stallD_o); end
        clear_inputs();
    endtask

    task automatic test_forward_e();
        clear_inputs();
        RegWriteM_i = 1'b1; WriteRegM_i = 5'd5; RegWriteW_i = 1'b1; WriteRegW_i = 5'd5; RsE_i = 5'd5; #1;
        n_cmp++; if (forwardAE_o !== 2'b10) begin n_err++; $display("FAIL fwdAE_m_wins got=%b exp=10", forwardAE_o); end
        WriteRegM_i = 5'd0; WriteRegW_i = 5'd0; RsE_i = 5'd0; #1;
        n_cmp++; if (forwardAE_o !== 2'b00) begin n_err++; $display("FAIL fwdAE_r0 got=%b exp=00", forwardAE_o); end
        RegWriteM_i = 1'b0; WriteRegM_i = 5'd9; WriteRegW_i = 5'd9; RtE_i = 5'd9; #1;
        n_cmp++; if (forwardBE_o !== 2'b01) begin n_err++; $display("FAIL fwdBE_w got=%b exp=01", forwardBE_o); end
        RegWriteM_i = 1'b1; #1;
        n_cmp++; if (forwardBE_o !== 2'b10) begin n_err++; $display("FAIL fwdBE_m got=%b exp=10", forwardBE_o); end
        RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; RsE_i = 5'd9; #1;
        n_cmp++; if ({forwardAE_o, forwardBE_o} !== 4'b0000) begin n_err++; $display("FAIL fwdE_nowrite got=%b exp=0000", {forwardAE_o, forwardBE_o}); end
        RegWriteW_i = 1'b1; WriteRegW_i = 5'd12; RsE_i = 5'd12; #1;
        n_cmp++; if ({forwardAE_o, forwardBE_o} !== 4'b0100) begin n_err++; $display("FAIL fwdAE_w got=%b exp=0100", {forwardAE_o, forwardBE_o}); end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD_i = 2'b01; RsD_i = 5'd3; RegWriteE_i = 1'b1; WriteRegE_i = 5'd3; #1;
        n_cmp++; if ({stallF_o, stallD_o, flushE_o} !== 3'b111) begin n_err++; $display("FAIL br_e_stall got=%b exp=111", {stallF_o, stallD_o, flushE_o}); end
        tick();
        RegWriteE_i = 1'b0; WriteRegE_i = 5'd0; RegWriteM_i = 1'b1; WriteRegM_i = 5'd3; #1;
        n_cmp++; if ({stallD_o, forwardAD_o, forwardBD_o} !== 3'b010) begin n_err++; $display("FAIL br_fwdAD got=%b exp=010", {stallD_o, forwardAD_o, forwardBD_o}); end
        RsD_i = 5'd8; RtD_i = 5'd3; #1;
        n_cmp++; if ({forwardAD_o, forwardBD_o} !== 2'b01) begin n_err++; $display("FAIL br_fwdBD got=%b exp=01", {forwardAD_o, forwardBD_o}); end
        RegWriteM_i = 1'b0; WBSrcM_i = 3'b001; #1;
        n_cmp++; if (stallD_o !== 1'b1) begin n_err++; $display("FAIL br_load_m got=%0b exp=1", stallD_o); end
        branchD_i = 2'b00; #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL nobr_load_m got=%0b exp=0", stallD_o); end
        clear_inputs();
        branchD_i = 2'b10; RegWriteE_i = 1'b1; WriteRegE_i = 5'd0; #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL br_r0 got=%0b exp=0", stallD_o); end
        clear_inputs();
    endtask

    task automatic test_mult_wait();
        clear_inputs();
        MultStartE_i = 1'b1; WBSrcD_i = 3'b100; #1;
        n_cmp++; if ({mult_busy_o, stallD_o} !== 2'b00) begin n_err++; $display("FAIL mult_launch got=%b exp=00", {mult_busy_o, stallD_o}); end
        tick();
        MultStartE_i = 1'b0; #1;
        n_cmp++; if ({mult_busy_o, stallD_o} !== 2'b11) begin n_err++; $display("FAIL mult_mflo_stall got=%b exp=11", {mult_busy_o, stallD_o}); end
        tick();
        WBSrcD_i = 3'b000; MultStartD_i = 1'b1; #1;
        n_cmp++; if (stallD_o !== 1'b1) begin n_err++; $display("FAIL mult_multD_stall got=%0b exp=1", stallD_o); end
        MultStartD_i = 1'b0; #1;
        n_cmp++; if (stallD_o !== 1'b0) begin n_err++; $display("FAIL mult_indep got=%0b exp=0", stallD_o); end
        tick();
        WBSrcD_i = 3'b100; MultDoneE_i = 1'b1; #1;
        n_cmp++; if ({mult_busy_o, stallD_o} !== 2'b11) begin n_err++; $display("FAIL mult_done_cycle got=%b exp=11", {mult_busy_o, stallD_o}); end
        tick();
        MultDoneE_i = 1'b0; #1;
        n_cmp++; if ({mult_busy_o, stallD_o} !== 2'b00) begin n_err++; $display("FAIL mult_after_done got=%b exp=00", {mult_busy_o, stallD_o}); end
        MultDoneE_i = 1'b1; tick();
        n_cmp++; if (mult_busy_o !== 1'b0) begin n_err++; $display("FAIL mult_idle_done got=%0b exp=0", mult_busy_o); end
        MultStartE_i = 1'b1; tick();
        n_cmp++; if (mult_busy_o !== 1'b0) begin n_err++; $display("FAIL mult_single_cycle got=%0b exp=0", mult_busy_o); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        MultStartE_i = 1'b1; tick();
        MultStartE_i = 1'b0;
        repeat (60) tick();
        MultStartE_i = 1'b1; MultDoneE_i = 1'b1; tick();
        MultStartE_i = 1'b0; MultDoneE_i = 1'b0;
        repeat (63) tick();
        n_cmp++; if ({mult_busy_o, mult_err_o} !== 2'b10) begin n_err++; $display("FAIL b2b_restart got=%b exp=10", {mult_busy_o, mult_err_o}); end
        MultDoneE_i = 1'b1; tick();
        MultDoneE_i = 1'b0;
        n_cmp++; if ({mult_busy_o, mult_err_o} !== 2'b00) begin n_err++; $display("FAIL b2b_done got=%b exp=00", {mult_busy_o, mult_err_o}); end
    endtask

    task automatic test_timeout();
        clear_inputs();
        MultStartE_i = 1'b1; tick();
        MultStartE_i = 1'b0; WBSrcD_i = 3'b100;
        repeat (63) tick();
        n_cmp++; if ({mult_busy_o, mult_err_o, stallD_o} !== 3'b101) begin n_err++; $display("FAIL to_last_busy got=%b exp=101", {mult_busy_o, mult_err_o, stallD_o}); end
        tick();
        n_cmp++; if ({mult_busy_o, mult_err_o, stallD_o} !== 3'b010) begin n_err++; $display("FAIL to_err got=%b exp=010", {mult_busy_o, mult_err_o, stallD_o}); end
        MultStartE_i = 1'b1; tick();
        MultStartE_i = 1'b0; MultDoneE_i = 1'b1; tick();
        MultDoneE_i = 1'b0; tick();
        n_cmp++; if ({mult_busy_o, mult_err_o} !== 2'b01) begin n_err++; $display("FAIL to_sticky got=%b exp=01", {mult_busy_o, mult_err_o}); end
        rst_i = 1'b1; tick();
        rst_i = 1'b0; #1;
        n_cmp++; if ({mult_busy_o, mult_err_o} !== 2'b00) begin n_err++; $display("FAIL to_rst_clear got=%b exp=00", {mult_busy_o, mult_err_o}); end
        clear_inputs();
    endtask

    task automatic test_reset_busy_saturation();
        clear_inputs();
        MultStartE_i = 1'b1; tick();
        MultStartE_i = 1'b0; #1;
        n_cmp++; if (mult_busy_o !== 1'b1) begin n_err++; $display("FAIL rb_busy got=%0b exp=1", mult_busy_o); end
        rst_i = 1'b1; #1;
        n_cmp++; if ({mult_busy_o, flushE_o, stall_cnt_o} !== {2'b01, 16'd0}) begin n_err++; $display("FAIL rb_during got=%b exp=01_0", {mult_busy_o, flushE_o, stall_cnt_o}); end
        tick();
        rst_i = 1'b0; #1;
        n_cmp++; if ({mult_busy_o, stall_cnt_o} !== {1'b0, 16'd0}) begin n_err++; $display("FAIL rb_after got=%b exp=0_0", {mult_busy_o, stall_cnt_o}); end
        WBSrcE_i = 3'b001; RtE_i = 5'd6; RsD_i = 5'd6;
        repeat (65534) tick();
        n_cmp++; if (stall_cnt_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt_o); end
        repeat (7) tick();
        n_cmp++; if (stall_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt_o); end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward_e();
        test_branch();
        test_mult_wait();
        test_back_to_back();
        test_timeout();
        test_reset_busy_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
